wbc_router_ng: RTL and testbench

- Next-generation Wishbone classic 1-to-NS router for the boot/misc and peripheral regions of the base system.
- Decodes the top MUXWIDTH address bits against a per-slave match table. Registers the request and response paths.
- Adds three behaviours: error response for unmapped addresses, a per-transaction watchdog timeout, and sticky fault capture readable by firmware.

---
 rtl/wbc_pkg.sv | 46 ++++
 rtl/wbc_watchdog.sv | 29 ++
 rtl/wbc_router_ng.sv | 171 +++++++++++++++++
 tb/tb_wbc_router_ng.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wbc_pkg.sv
// rtl/wbc_pkg.sv - shared types, fault codes and slave decode for the wishbone router
package wbc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } router_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_UNMAPPED = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_SLVERR   = 2'b11;

  // Decode works on a table widened to the largest supported shape.
  localparam int MAX_NS = 16;
  localparam int MAX_MW = 8;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } decode_t;

  function automatic decode_t decode_slave(
    input logic [MAX_MW-1:0]        addr_bits,
    input logic [MAX_NS*MAX_MW-1:0] match_table,
    input int                       ns,
    input int                       mw
  );
    decode_t           r;
    logic [MAX_MW-1:0] mask;
    logic [MAX_MW-1:0] ent;
    r    = '0;
    mask = MAX_MW'((1 << mw) - 1);
    for (int k = 0; k < MAX_NS; k++) begin
      ent = MAX_MW'(match_table >> (k * mw)) & mask;
      if (!r.hit && (k < ns) && (ent == (addr_bits & mask))) begin
        r.hit = 1'b1;
        r.idx = 4'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wbc_watchdog.sv
// rtl/wbc_watchdog.sv - saturating transaction watchdog; expire marks the edge the count reaches TIMEOUT
module wbc_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && en && (count == LIMIT - CW'(1));

endmodule

// File: rtl/wbc_router_ng.sv
// rtl/wbc_router_ng.sv - registered wishbone classic 1-to-NS router with unmapped/timeout/slave-error fault capture
module wbc_router_ng
  import wbc_pkg::*;
#(
  parameter int                     AW        = 28,
  parameter int                     DW        = 32,
  parameter int                     NS        = 2,
  parameter int                     MUXWIDTH  = 1,
  parameter logic [NS*MUXWIDTH-1:0] SLAVE_MUX = '0,
  parameter int                     TIMEOUT   = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_mcyc,
  input  logic                         i_mstb,
  input  logic                         i_mwe,
  input  logic [AW-1:0]                i_maddr,
  input  logic [DW-1:0]                i_mdata,
  input  logic [DW/8-1:0]              i_msel,
  output logic                         o_mack,
  output logic                         o_merr,
  output logic [DW-1:0]                o_mdata,
  output logic [NS-1:0]                o_scyc,
  output logic [NS-1:0]                o_sstb,
  output logic [NS-1:0]                o_swe,
  output logic [NS*(AW-MUXWIDTH)-1:0]  o_saddr,
  output logic [NS*DW-1:0]             o_sdata,
  output logic [NS*(DW/8)-1:0]         o_ssel,
  input  logic [NS-1:0]                i_sack,
  input  logic [NS-1:0]                i_serr,
  input  logic [NS*DW-1:0]             i_sdata,
  input  logic                         i_fault_clr,
  output logic                         o_fault_valid,
  output logic [1:0]                   o_fault_code,
  output logic [AW-1:0]                o_fault_addr
);

  localparam int SAW = AW - MUXWIDTH;
  localparam int IW  = (NS > 1) ? $clog2(NS) : 1;
  localparam int TW  = MAX_NS * MAX_MW;
  localparam logic [TW-1:0] TABLE_EXT = TW'(SLAVE_MUX);

  router_state_t state;
  logic [IW-1:0] sel_idx;
  logic [AW-1:0] req_addr;
  logic          req_we;
  decode_t       dec;
  logic          wd_expire;
  logic          sack_k, serr_k;
  logic [DW-1:0] sdata_k;
  logic          fault_set;
  logic [1:0]    fault_code_n;
  logic [AW-1:0] fault_addr_n;

  assign dec     = decode_slave(MAX_MW'(i_maddr[AW-1 -: MUXWIDTH]), TABLE_EXT, NS, MUXWIDTH);
  assign sack_k  = i_sack[sel_idx];
  assign serr_k  = i_serr[sel_idx];
  assign sdata_k = i_sdata[int'(sel_idx)*DW +: DW];

  wbc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (i_clk),
    .rst_n  (i_reset_n),
    .clr    (state != ST_ACTIVE),
    .en     (state == ST_ACTIVE),
    .expire (wd_expire)
  );

  always_comb begin
    fault_set    = 1'b0;
    fault_code_n = FAULT_NONE;
    fault_addr_n = req_addr;
    if (state == ST_IDLE && i_mcyc && i_mstb && !dec.hit) begin
      fault_set    = 1'b1;
      fault_code_n = FAULT_UNMAPPED;
      fault_addr_n = i_maddr;
    end else if (state == ST_ACTIVE && i_mcyc) begin
      if (serr_k) begin
        fault_set    = 1'b1;
        fault_code_n = FAULT_SLVERR;
      end else if (!sack_k && wd_expire) begin
        fault_set    = 1'b1;
        fault_code_n = FAULT_TIMEOUT;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= ST_IDLE;
      sel_idx  <= '0;
      req_addr <= '0;
      req_we   <= 1'b0;
      o_mack   <= 1'b0;
      o_merr   <= 1'b0;
      o_mdata  <= '0;
      o_scyc   <= '0;
      o_sstb   <= '0;
      o_swe    <= '0;
      o_saddr  <= '0;
      o_sdata  <= '0;
      o_ssel   <= '0;
    end else begin
      o_mack <= 1'b0;
      o_merr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_mcyc && i_mstb) begin
            req_addr <= i_maddr;
            req_we   <= i_mwe;
            o_saddr  <= {NS{i_maddr[SAW-1:0]}};
            o_sdata  <= {NS{i_mdata}};
            o_ssel   <= {NS{i_msel}};
            o_swe    <= {NS{i_mwe}};
            if (dec.hit) begin
              sel_idx <= IW'(dec.idx);
              o_scyc  <= NS'(1) << dec.idx;
              o_sstb  <= NS'(1) << dec.idx;
              state   <= ST_ACTIVE;
            end else begin
              o_merr <= 1'b1;
              state  <= ST_ERR;
            end
          end
        end
        ST_ACTIVE: begin
          // Priority: master abort, then slave error, then ack, then watchdog.
          if (!i_mcyc) begin
            o_scyc <= '0;
            o_sstb <= '0;
            state  <= ST_IDLE;
          end else if (serr_k) begin
            o_scyc <= '0;
            o_sstb <= '0;
            o_merr <= 1'b1;
            state  <= ST_RESP;
          end else if (sack_k) begin
            o_scyc <= '0;
            o_sstb <= '0;
            o_mack <= 1'b1;
            if (!req_we) o_mdata <= sdata_k;
            state  <= ST_RESP;
          end else if (wd_expire) begin
            o_scyc <= '0;
            o_sstb <= '0;
            o_merr <= 1'b1;
            state  <= ST_RESP;
          end
        end
        ST_RESP, ST_ERR: state <= ST_IDLE;
        default:         state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_fault_valid <= 1'b0;
      o_fault_code  <= FAULT_NONE;
      o_fault_addr  <= '0;
    end else if (fault_set && (!o_fault_valid || i_fault_clr)) begin
      o_fault_valid <= 1'b1;
      o_fault_code  <= fault_code_n;
      o_fault_addr  <= fault_addr_n;
    end else if (i_fault_clr) begin
      o_fault_valid <= 1'b0;
      o_fault_code  <= FAULT_NONE;
      o_fault_addr  <= '0;
    end
  end

endmodule

// File: tb/tb_wbc_router_ng.sv
// tb/tb_wbc_router_ng.sv - directed table-driven bench for wbc_router_ng
module tb_wbc_router_ng;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_mcyc, a_mstb, a_mwe, a_mack, a_merr, a_fclr, a_fv;
  logic [27:0] a_maddr, a_fa;
  logic [31:0] a_wdat, a_rdat;
  logic [3:0]  a_msel;
  logic [1:0]  a_scyc, a_sstb, a_swe, a_sack, a_serr, a_fc;
  logic [53:0] a_saddr;
  logic [63:0] a_sdat_o, a_sdat_i;
  logic [7:0]  a_ssel;

  logic        b_mcyc, b_mstb, b_mwe, b_mack, b_merr, b_fclr, b_fv;
  logic [27:0] b_maddr, b_fa;
  logic [31:0] b_wdat, b_rdat;
  logic [3:0]  b_msel;
  logic [2:0]  b_scyc, b_sstb, b_swe, b_sack, b_serr;
  logic [1:0]  b_fc;
  logic [77:0] b_saddr;
  logic [95:0] b_sdat_o, b_sdat_i;
  logic [11:0] b_ssel;

  wbc_router_ng #(.AW(28), .DW(32), .NS(2), .MUXWIDTH(1), .SLAVE_MUX(2'b10), .TIMEOUT(8)) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_mcyc(a_mcyc), .i_mstb(a_mstb), .i_mwe(a_mwe),
    .i_maddr(a_maddr), .i_mdata(a_wdat), .i_msel(a_msel), .o_mack(a_mack), .o_merr(a_merr),
    .o_mdata(a_rdat), .o_scyc(a_scyc), .o_sstb(a_sstb), .o_swe(a_swe), .o_saddr(a_saddr),
    .o_sdata(a_sdat_o), .o_ssel(a_ssel), .i_sack(a_sack), .i_serr(a_serr), .i_sdata(a_sdat_i),
    .i_fault_clr(a_fclr), .o_fault_valid(a_fv), .o_fault_code(a_fc), .o_fault_addr(a_fa)
  );

  wbc_router_ng #(.AW(28), .DW(32), .NS(3), .MUXWIDTH(2), .SLAVE_MUX({2'd0, 2'd1, 2'd2}), .TIMEOUT(8)) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_mcyc(b_mcyc), .i_mstb(b_mstb), .i_mwe(b_mwe),
    .i_maddr(b_maddr), .i_mdata(b_wdat), .i_msel(b_msel), .o_mack(b_mack), .o_merr(b_merr),
    .o_mdata(b_rdat), .o_scyc(b_scyc), .o_sstb(b_sstb), .o_swe(b_swe), .o_saddr(b_saddr),
    .o_sdata(b_sdat_o), .o_ssel(b_ssel), .i_sack(b_sack), .i_serr(b_serr), .i_sdata(b_sdat_i),
    .i_fault_clr(b_fclr), .o_fault_valid(b_fv), .o_fault_code(b_fc), .o_fault_addr(b_fa)
  );

  typedef struct {
    logic [27:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_n;
    logic [1:0]  resp;
    logic [1:0]  onehot;
    logic        exp_ack;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_mdata;
    logic        exp_fv;
    logic [1:0]  exp_fc;
    logic [27:0] exp_fa;
    logic        clr_after;
  } vec_t;

  vec_t vecs[8];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_a(input int idx, input vec_t v);
    int         n;
    int         stb_cyc;
    int         k;
    logic [1:0] stb_seen;
    logic       seen;
    k        = v.onehot[1] ? 1 : 0;
    a_mcyc   = 1'b1;
    a_mstb   = 1'b1;
    a_maddr  = v.addr;
    a_mwe    = v.we;
    a_wdat   = v.wdata;
    a_msel   = v.we ? 4'b0011 : 4'b1111;
    a_sdat_i = (k == 1) ? {v.rdata, ~v.rdata} : {~v.rdata, v.rdata};
    step();
    chk($sformatf("v%0d_stb", idx), a_sstb, v.onehot);
    chk($sformatf("v%0d_saddr", idx), a_saddr, {2{v.addr[26:0]}});
    chk($sformatf("v%0d_sdata", idx), a_sdat_o, {2{v.wdata}});
    chk($sformatf("v%0d_ssel", idx), a_ssel, {2{a_msel}});
    chk($sformatf("v%0d_swe", idx), a_swe, {2{v.we}});
    stb_seen = a_sstb;
    stb_cyc  = (a_sstb != 2'b00) ? 1 : 0;
    n        = 0;
    seen     = 1'b0;
    while (!seen && n < 40) begin
      a_sack = (n == v.wait_n && v.resp[0]) ? v.onehot : 2'b00;
      a_serr = (n == v.wait_n && v.resp[1]) ? v.onehot : 2'b00;
      step();
      n++;
      a_sack   = 2'b00;
      a_serr   = 2'b00;
      stb_seen = stb_seen | a_sstb;
      if (a_mack || a_merr) seen = 1'b1;
      else if (a_sstb != 2'b00) stb_cyc++;
    end
    chk($sformatf("v%0d_ack", idx), a_mack, v.exp_ack);
    chk($sformatf("v%0d_err", idx), a_merr, v.exp_err);
    chk($sformatf("v%0d_latency", idx), n, v.exp_lat);
    chk($sformatf("v%0d_stb_cycles", idx), stb_cyc, v.exp_lat);
    chk($sformatf("v%0d_stb_only_sel", idx), stb_seen, v.onehot);
    chk($sformatf("v%0d_mdata", idx), a_rdat, v.exp_mdata);
    a_mcyc = 1'b0;
    a_mstb = 1'b0;
    step();
    chk($sformatf("v%0d_resp_pulse", idx), {a_mack, a_merr}, 2'b00);
    chk($sformatf("v%0d_fault_valid", idx), a_fv, v.exp_fv);
    if (v.exp_fv) begin
      chk($sformatf("v%0d_fault_code", idx), a_fc, v.exp_fc);
      chk($sformatf("v%0d_fault_addr", idx), a_fa, v.exp_fa);
    end
    if (v.clr_after) begin
      a_fclr = 1'b1;
      step();
      a_fclr = 1'b0;
      chk($sformatf("v%0d_fault_clr", idx), a_fv, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{28'h0000010, 1'b0, 32'h0, 32'hDEADBEEF, 0, 2'b01, 2'b01, 1'b1, 1'b0, 1, 32'hDEADBEEF, 1'b0, 2'b00, 28'h0, 1'b0};
    vecs[1] = '{28'h8000123, 1'b0, 32'h0, 32'h12345678, 5, 2'b01, 2'b10, 1'b1, 1'b0, 6, 32'h12345678, 1'b0, 2'b00, 28'h0, 1'b0};
    vecs[2] = '{28'h0000044, 1'b1, 32'hCAFEF00D, 32'hFFFFFFFF, 2, 2'b01, 2'b01, 1'b1, 1'b0, 3, 32'h12345678, 1'b0, 2'b00, 28'h0, 1'b0};
    vecs[3] = '{28'h0000001, 1'b0, 32'h0, 32'h0, 99, 2'b00, 2'b01, 1'b0, 1'b1, 8, 32'h12345678, 1'b1, 2'b10, 28'h0000001, 1'b0};
    vecs[4] = '{28'h8000002, 1'b0, 32'h0, 32'h55555555, 1, 2'b11, 2'b10, 1'b0, 1'b1, 2, 32'h12345678, 1'b1, 2'b10, 28'h0000001, 1'b1};
    vecs[5] = '{28'h8000003, 1'b0, 32'h0, 32'h0BADF00D, 7, 2'b01, 2'b10, 1'b1, 1'b0, 8, 32'h0BADF00D, 1'b0, 2'b00, 28'h0, 1'b0};
    vecs[6] = '{28'h0000005, 1'b0, 32'h0, 32'h0, 0, 2'b10, 2'b01, 1'b0, 1'b1, 1, 32'h0BADF00D, 1'b1, 2'b11, 28'h0000005, 1'b1};
    vecs[7] = '{28'h8000006, 1'b0, 32'h0, 32'h0, 3, 2'b11, 2'b10, 1'b0, 1'b1, 4, 32'h0BADF00D, 1'b1, 2'b11, 28'h8000006, 1'b0};

    rst_n = 1'b0;
    {a_mcyc, a_mstb, a_mwe, a_fclr} = '0;
    a_maddr = '0; a_wdat = '0; a_msel = '0; a_sack = '0; a_serr = '0; a_sdat_i = '0;
    {b_mcyc, b_mstb, b_mwe, b_fclr} = '0;
    b_maddr = '0; b_wdat = '0; b_msel = '0; b_sack = '0; b_serr = '0; b_sdat_i = '0;
    step();
    step();
    chk("rst_resp", {a_mack, a_merr}, 2'b00);
    chk("rst_mdata", a_rdat, 32'h0);
    chk("rst_scyc_sstb", {a_scyc, a_sstb}, 4'h0);
    chk("rst_saddr", a_saddr, 54'h0);
    chk("rst_fault", {a_fv, a_fc, a_fa}, 31'h0);
    chk("rst_b_fault", {b_fv, b_fc, b_fa}, 31'h0);
    rst_n = 1'b1;
    step();

    // Unmapped decode on the 3-slave instance
    b_maddr = 28'hC0ABCDE;
    b_mcyc  = 1'b1;
    b_mstb  = 1'b1;
    step();
    chk("b_unmapped_merr", b_merr, 1'b1);
    chk("b_unmapped_scyc", b_scyc, 3'b000);
    chk("b_unmapped_fv", b_fv, 1'b1);
    chk("b_unmapped_code", b_fc, 2'b01);
    chk("b_unmapped_addr", b_fa, 28'hC0ABCDE);
    b_mcyc = 1'b0;
    b_mstb = 1'b0;
    step();
    chk("b_unmapped_pulse", b_merr, 1'b0);
    b_maddr  = 28'h0000042;
    b_mcyc   = 1'b1;
    b_mstb   = 1'b1;
    b_sdat_i = {32'hA5A5A5A5, 32'h11111111, 32'h22222222};
    step();
    chk("b_map_sstb", b_sstb, 3'b100);
    chk("b_map_saddr", b_saddr[52 +: 26], 26'h0000042);
    b_sack = 3'b100;
    step();
    b_sack = 3'b000;
    chk("b_map_ack", b_mack, 1'b1);
    chk("b_map_mdata", b_rdat, 32'hA5A5A5A5);
    chk("b_map_fault_kept", b_fa, 28'hC0ABCDE);
    b_mcyc = 1'b0;
    b_mstb = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_a(i, vecs[i]);

    // Clear and a new slave error in the same cycle: the new fault is kept
    a_maddr = 28'h0000007; a_mwe = 1'b0; a_mcyc = 1'b1; a_mstb = 1'b1;
    step();
    a_serr = 2'b01;
    a_fclr = 1'b1;
    step();
    a_serr = 2'b00;
    a_fclr = 1'b0;
    chk("clrfault_merr", a_merr, 1'b1);
    chk("clrfault_fv", a_fv, 1'b1);
    chk("clrfault_code", a_fc, 2'b11);
    chk("clrfault_addr", a_fa, 28'h0000007);
    a_mcyc = 1'b0; a_mstb = 1'b0;
    step();

    // Master abort in ACTIVE
    a_maddr = 28'h0000020; a_mcyc = 1'b1; a_mstb = 1'b1;
    step();
    chk("abort_stb_up", a_sstb, 2'b01);
    a_mcyc = 1'b0; a_mstb = 1'b0;
    step();
    chk("abort_scyc", {a_scyc, a_sstb}, 4'h0);
    chk("abort_resp", {a_mack, a_merr}, 2'b00);
    step();
    chk("abort_resp2", {a_mack, a_merr}, 2'b00);
    chk("abort_no_fault", a_fa, 28'h0000007);

    // Asynchronous reset in ACTIVE
    a_maddr = 28'h8000009; a_mcyc = 1'b1; a_mstb = 1'b1;
    step();
    chk("rstmid_stb_up", a_sstb, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("rstmid_scyc_sstb", {a_scyc, a_sstb}, 4'h0);
    chk("rstmid_saddr", a_saddr, 54'h0);
    chk("rstmid_fault", {a_fv, a_fa}, 29'h0);
    a_mcyc = 1'b0; a_mstb = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
